// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects four push buttons and one slide switch.
// Define BUTTON_CONDITIONER_AUTOREPEAT_EN to add hold-to-repeat on Aumentar/Disminuir.
module button_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  input  logic       sw_raw,
  output logic       Left,
  output logic       Right,
  output logic       Aumentar,
  output logic       Disminuir,
  output logic       Switch0,
  output logic [3:0] btn_level
);

  localparam int CNT_W = $clog2(32'(DEBOUNCE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  // Bit order: [3:0] buttons as in btn_raw, [4] switch.
  logic [4:0]       raw;
  logic [4:0]       sync_p0;
  logic [4:0]       sync_p1;
  logic [4:0]       level_p2;
  logic [4:0]       level_p3;
  logic [CNT_W-1:0] db_cnt [5];
  logic [3:0]       press;
  logic [3:0]       rep_hit;
  logic [3:0]       cand;
  logic [3:0]       cmd_next;

  assign raw = {sw_raw, btn_raw};

  // Stages p0/p1: two-flop synchronizer; p2: debounced level; p3: delayed level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      level_p2 <= '0;
      level_p3 <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0  <= raw;
      sync_p1  <= sync_p0;
      level_p3 <= level_p2;
      for (int i = 0; i < 5; i++) begin
        if (sync_p1[i] == level_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level_p2[i] <= ~level_p2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = level_p2[3:0] & ~level_p3[3:0];

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  // Repeat timing runs off the delayed level so it starts in the press-pulse cycle.
  logic [23:0] rep_cnt [2];
  logic [1:0]  rep_started;

  always_comb begin
    rep_hit = '0;
    for (int j = 0; j < 2; j++) begin
      rep_hit[2+j] = level_p3[2+j] &&
        (rep_cnt[j] == (rep_started[j] ? (REPEAT_PERIOD - 24'd1) : (REPEAT_DELAY - 24'd1)));
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (reset || !level_p3[2+j]) begin
        rep_cnt[j]     <= '0;
        rep_started[j] <= 1'b0;
      end else if (rep_hit[2+j]) begin
        rep_cnt[j]     <= '0;
        rep_started[j] <= 1'b1;
      end else begin
        rep_cnt[j] <= rep_cnt[j] + 24'd1;
      end
    end
  end
`else
  assign rep_hit = '0;
`endif

  assign cand = press | rep_hit;

  // Fixed priority Right > Left > Aumentar > Disminuir; losers are dropped.
  always_comb begin
    cmd_next = '0;
    if (cand[1])      cmd_next[1] = 1'b1;
    else if (cand[0]) cmd_next[0] = 1'b1;
    else if (cand[2]) cmd_next[2] = 1'b1;
    else if (cand[3]) cmd_next[3] = 1'b1;
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      Left      <= 1'b0;
      Right     <= 1'b0;
      Aumentar  <= 1'b0;
      Disminuir <= 1'b0;
    end else begin
      Left      <= cmd_next[0];
      Right     <= cmd_next[1];
      Aumentar  <= cmd_next[2];
      Disminuir <= cmd_next[3];
    end
  end

  assign btn_level = level_p3[3:0];
  assign Switch0   = level_p3[4];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = '0;
  logic       sw_raw = 1'b0;
  logic       Left, Right, Aumentar, Disminuir, Switch0;
  logic [3:0] btn_level;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] cmd;
    logic [4:0] lvl;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [3:0] got_cmd;
  logic [4:0] got_lvl;

  button_conditioner #(
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY   (24'd20),
    .REPEAT_PERIOD  (24'd8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .Left     (Left),
    .Right    (Right),
    .Aumentar (Aumentar),
    .Disminuir(Disminuir),
    .Switch0  (Switch0),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  // Drive one edge's inputs while clk is low, clock it, then sample on the falling edge.
  task automatic drive_cycle(input logic [3:0] b, input logic s, input logic r);
    btn_raw = b;
    sw_raw  = s;
    reset   = r;
    @(posedge clk);
    @(negedge clk);
    got_cmd = {Disminuir, Aumentar, Right, Left};
    got_lvl = {Switch0, btn_level};
  endtask

  task automatic apply_reset();
    drive_cycle(4'b0000, 1'b0, 1'b1);
    drive_cycle(4'b0000, 1'b0, 1'b1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive_cycle(4'b1111, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{cmd: 4'b0000, lvl: 5'b00000});
      drive_cycle(4'b1111, 1'b1, 1'b1);
      e = sb.pop_front();
      checks++;
      if (got_cmd !== e.cmd) begin
        errors++; $display("FAIL reset_cmd k=%0d got %b want %b", k, got_cmd, e.cmd);
      end
      checks++;
      if (got_lvl !== e.lvl) begin
        errors++; $display("FAIL reset_lvl k=%0d got %b want %b", k, got_lvl, e.lvl);
      end
    end
    apply_reset();
  endtask

  task automatic test_press();
    apply_reset();
    for (int k = 0; k < 45; k++) begin
      sb.push_back('{cmd: (k == 6) ? 4'b0100 : 4'b0000,
                     lvl: (k >= 6 && k < 36) ? 5'b00100 : 5'b00000});
      drive_cycle((k < 30) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (got_cmd !== e.cmd) begin
        errors++; $display("FAIL press_cmd k=%0d got %b want %b", k, got_cmd, e.cmd);
      end
      checks++;
      if (got_lvl !== e.lvl) begin
        errors++; $display("FAIL press_lvl k=%0d got %b want %b", k, got_lvl, e.lvl);
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      sb.push_back('{cmd: 4'b0000, lvl: 5'b00000});
      drive_cycle((k < 3) ? 4'b0010 : 4'b0000, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (got_cmd !== e.cmd) begin
        errors++; $display("FAIL glitch_cmd k=%0d got %b want %b", k, got_cmd, e.cmd);
      end
      checks++;
      if (got_lvl !== e.lvl) begin
        errors++; $display("FAIL glitch_lvl k=%0d got %b want %b", k, got_lvl, e.lvl);
      end
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      sb.push_back('{cmd: (k == 6) ? 4'b0010 : 4'b0000,
                     lvl: (k >= 6) ? 5'b00011 : 5'b00000});
      drive_cycle(4'b0011, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (got_cmd !== e.cmd) begin
        errors++; $display("FAIL simul_cmd k=%0d got %b want %b", k, got_cmd, e.cmd);
      end
      checks++;
      if (got_lvl !== e.lvl) begin
        errors++; $display("FAIL simul_lvl k=%0d got %b want %b", k, got_lvl, e.lvl);
      end
    end
  endtask

  task automatic test_priority_left_aum();
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      sb.push_back('{cmd: (k == 6) ? 4'b0001 : 4'b0000,
                     lvl: (k >= 6) ? 5'b00101 : 5'b00000});
      drive_cycle(4'b0101, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (got_cmd !== e.cmd) begin
        errors++; $display("FAIL prio_cmd k=%0d got %b want %b", k, got_cmd, e.cmd);
      end
      checks++;
      if (got_lvl !== e.lvl) begin
        errors++; $display("FAIL prio_lvl k=%0d got %b want %b", k, got_lvl, e.lvl);
      end
    end
  endtask

  task automatic test_autorepeat();
    logic pulse;
    apply_reset();
    for (int k = 0; k < 80; k++) begin
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      pulse = (k == 6) || (k == 26) || (k >= 34 && k <= 66 && ((k - 34) % 8 == 0));
`else
      pulse = (k == 6);
`endif
      sb.push_back('{cmd: pulse ? 4'b1000 : 4'b0000,
                     lvl: (k >= 6 && k < 66) ? 5'b01000 : 5'b00000});
      drive_cycle((k < 60) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (got_cmd !== e.cmd) begin
        errors++; $display("FAIL repeat_cmd k=%0d got %b want %b", k, got_cmd, e.cmd);
      end
      checks++;
      if (got_lvl !== e.lvl) begin
        errors++; $display("FAIL repeat_lvl k=%0d got %b want %b", k, got_lvl, e.lvl);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      sb.push_back('{cmd: (k == 11) ? 4'b0001 : 4'b0000,
                     lvl: (k >= 11) ? 5'b00001 : 5'b00000});
      drive_cycle(4'b0001, 1'b0, (k == 3 || k == 4));
      e = sb.pop_front();
      checks++;
      if (got_cmd !== e.cmd) begin
        errors++; $display("FAIL midrst_cmd k=%0d got %b want %b", k, got_cmd, e.cmd);
      end
      checks++;
      if (got_lvl !== e.lvl) begin
        errors++; $display("FAIL midrst_lvl k=%0d got %b want %b", k, got_lvl, e.lvl);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_switch();
    apply_reset();
    for (int k = 0; k < 15; k++) begin
      sb.push_back('{cmd: 4'b0000, lvl: (k >= 6) ? 5'b10000 : 5'b00000});
      drive_cycle(4'b0000, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if (got_cmd !== e.cmd) begin
        errors++; $display("FAIL switch_cmd k=%0d got %b want %b", k, got_cmd, e.cmd);
      end
      checks++;
      if (got_lvl !== e.lvl) begin
        errors++; $display("FAIL switch_lvl k=%0d got %b want %b", k, got_lvl, e.lvl);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_press();
    test_glitch();
    test_simultaneous();
    test_priority_left_aum();
    test_autorepeat();
    test_reset_mid_debounce();
    test_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
